// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and colour type for the VGA timing block.
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;

  localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_VISIBLE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VISIBLE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  typedef logic [11:0] rgb_t;

  localparam rgb_t RGB_BLACK = 12'h000;

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-rate enable: one-clk pulse every CLK_DIV system clocks (constant high for CLK_DIV=1).
module vga_pix_tick
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (rst)                 div_cnt <= '0;
    else if (div_cnt == LAST) div_cnt <= '0;
    else                     div_cnt <= div_cnt + CW'(1);
  end

  assign pix_tick = (div_cnt == LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster generator: pixel counters, visible/sync decode and a one-tick output
// register that keeps colour and sync aligned at the connector.
module vga_timing_ctrl #(
  parameter int   CLK_DIV     = 4,
  parameter int   H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
  parameter int   H_FP        = vga_timing_pkg::H_FP,
  parameter int   H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int   H_BP        = vga_timing_pkg::H_BP,
  parameter int   V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
  parameter int   V_FP        = vga_timing_pkg::V_FP,
  parameter int   V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int   V_BP        = vga_timing_pkg::V_BP,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        pix_valid,
  output logic        vblank_start,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);
  import vga_timing_pkg::*;

  localparam logic [9:0] H_LAST     = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST     = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
  localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic       pix_tick;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       line_end;
  logic       vis;
  logic       hs_raw;
  logic       vs_raw;
  rgb_t       rgb_p1;
  logic       hsync_p1;
  logic       vsync_p1;
  logic       vblank_p1;

  vga_pix_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick (
    .clk      (clk),
    .rst      (rst),
    .pix_tick (pix_tick)
  );

  assign line_end = (h_cnt == H_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (line_end) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Stage 1: combinational decode of the counter state
  assign vis       = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
  assign pix_valid = vis;
  assign pix_x     = vis ? h_cnt : '0;
  assign pix_y     = vis ? v_cnt[8:0] : '0;
  assign hs_raw    = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign vs_raw    = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

  // Stage 2: pin register, one pixel tick behind stage 1
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_p1    <= RGB_BLACK;
      hsync_p1  <= ~SYNC_ACTIVE;
      vsync_p1  <= ~SYNC_ACTIVE;
      vblank_p1 <= 1'b0;
    end else begin
      vblank_p1 <= pix_tick && line_end && (v_cnt == V_VIS_LAST);
      if (pix_tick) begin
        rgb_p1   <= vis ? rgb_in : RGB_BLACK;
        hsync_p1 <= hs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_p1 <= vs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      end
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb_p1;
  assign hsync                 = hsync_p1;
  assign vsync                 = vsync_p1;
  assign vblank_start          = vblank_p1;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: default timing at CLK_DIV 4 and 1, plus a shrunken raster for frame-level behaviour.
module tb_vga_timing_ctrl;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic        valid;
    logic        vblank;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } obs_t;

  localparam int DT [3] = '{4, 1, 1};
  localparam int HV [3] = '{640, 640, 8};
  localparam int HF [3] = '{16, 16, 2};
  localparam int HS [3] = '{96, 96, 3};
  localparam int HB [3] = '{48, 48, 2};
  localparam int VV [3] = '{480, 480, 6};
  localparam int VF [3] = '{10, 10, 1};
  localparam int VS [3] = '{2, 2, 2};
  localparam int VB [3] = '{33, 33, 1};

  logic clk = 1'b0;
  logic [2:0] rst = 3'b111;
  bit          pat [3];
  logic [11:0] key [3];
  logic [11:0] cst [3];
  logic [2:0][11:0] rgb_in;
  wire  [2:0][9:0]  pix_x;
  wire  [2:0][8:0]  pix_y;
  wire  [2:0]       pix_valid, vblank, hsync, vsync;
  wire  [2:0][3:0]  vr, vg, vb;
  obs_t   obs [3];
  longint kc  [3];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    vga_timing_ctrl #(
      .CLK_DIV (DT[gi]), .H_VISIBLE (HV[gi]), .H_FP (HF[gi]), .H_SYNC (HS[gi]), .H_BP (HB[gi]),
      .V_VISIBLE (VV[gi]), .V_FP (VF[gi]), .V_SYNC (VS[gi]), .V_BP (VB[gi]), .SYNC_ACTIVE (1'b0)
    ) u_dut (
      .clk          (clk),
      .rst          (rst[gi]),
      .rgb_in       (rgb_in[gi]),
      .pix_x        (pix_x[gi]),
      .pix_y        (pix_y[gi]),
      .pix_valid    (pix_valid[gi]),
      .vblank_start (vblank[gi]),
      .hsync        (hsync[gi]),
      .vsync        (vsync[gi]),
      .vga_r        (vr[gi]),
      .vga_g        (vg[gi]),
      .vga_b        (vb[gi])
    );
  end

  // Colour stage stand-in: either a constant or a pattern built from the coordinates
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rgb_in[i] = pat[i] ? ({pix_x[i][3:0], pix_y[i][3:0], 4'h5} ^ key[i]) : cst[i];
      obs[i] = {pix_x[i], pix_y[i], pix_valid[i], vblank[i], hsync[i], vsync[i], vr[i], vg[i], vb[i]};
    end
  end

  // Clocks elapsed since the last clock edge that saw reset
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) kc[i] <= rst[i] ? 64'd0 : kc[i] + 64'd1;
  end

  // Reference: raster position = pixel ticks elapsed modulo frame size; pins show the previous tick's position
  function automatic obs_t model(input int i, input longint k);
    longint ht, vt, tk, p, h, v, q, hq, vq;
    obs_t o;
    ht = HV[i] + HF[i] + HS[i] + HB[i];
    vt = VV[i] + VF[i] + VS[i] + VB[i];
    tk = k / DT[i];
    p  = tk % (ht * vt);
    h  = p % ht;
    v  = p / ht;
    o = '0;
    o.valid = (h < HV[i]) && (v < VV[i]);
    if (o.valid) begin
      o.x = 10'(h);
      o.y = 9'(v);
    end
    o.vblank = (tk > 0) && (k % DT[i] == 0) && (p == VV[i] * ht);
    o.hs = 1'b1;
    o.vs = 1'b1;
    if (tk > 0) begin
      q  = (tk - 1) % (ht * vt);
      hq = q % ht;
      vq = q / ht;
      o.hs = !(hq >= HV[i] + HF[i] && hq < HV[i] + HF[i] + HS[i]);
      o.vs = !(vq >= VV[i] + VF[i] && vq < VV[i] + VF[i] + VS[i]);
      if (hq < HV[i] && vq < VV[i])
        o.rgb = pat[i] ? ({4'(hq), 4'(vq), 4'h5} ^ key[i]) : cst[i];
    end
    return o;
  endfunction

  task automatic do_reset(input int i, input int n);
    @(negedge clk);
    rst[i] = 1'b1;
    repeat (n) @(negedge clk);
    rst[i] = 1'b0;
  endtask

  task automatic test_reset(input int i);
    pat[i] = 1'b1;
    key[i] = 12'h000;
    do_reset(i, 1);
    repeat (1000 + $urandom_range(0, 500)) @(negedge clk);
    rst[i] = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (obs[i].rgb !== 12'h000) begin
      failures++; $display("FAIL reset_rgb[%0d] got=%h exp=000", i, obs[i].rgb);
    end
    checks++;
    if ({obs[i].hs, obs[i].vs} !== 2'b11) begin
      failures++; $display("FAIL reset_sync[%0d] got=%b exp=11", i, {obs[i].hs, obs[i].vs});
    end
    checks++;
    if (obs[i].vblank !== 1'b0) begin
      failures++; $display("FAIL reset_vblank[%0d] got=%b exp=0", i, obs[i].vblank);
    end
    checks++;
    if ({obs[i].x, obs[i].y, obs[i].valid} !== {10'd0, 9'd0, 1'b1}) begin
      failures++; $display("FAIL reset_pix[%0d] got=%0d,%0d,%b exp=0,0,1", i, obs[i].x, obs[i].y, obs[i].valid);
    end
    rst[i] = 1'b0;
    repeat (DT[i] - 1) @(negedge clk);
    checks++;
    if (obs[i].x !== 10'd0) begin
      failures++; $display("FAIL pre_tick_x[%0d] got=%0d exp=0", i, obs[i].x);
    end
    @(negedge clk);
    checks++;
    if (obs[i].x !== 10'd1) begin
      failures++; $display("FAIL first_tick_x[%0d] got=%0d exp=1", i, obs[i].x);
    end
    checks++;
    if (obs[i].rgb !== 12'h005) begin
      failures++; $display("FAIL first_tick_rgb[%0d] got=%h exp=005", i, obs[i].rgb);
    end
  endtask

  task automatic test_model_scan(input int i, input int ncyc);
    int   bad = 0;
    int   rc  = $urandom_range(ncyc / 4, ncyc / 2);
    int   rl  = $urandom_range(1, 4);
    obs_t e;
    pat[i] = 1'($urandom);
    key[i] = 12'($urandom);
    cst[i] = 12'($urandom);
    do_reset(i, $urandom_range(1, 3));
    for (int c = 0; c < ncyc && bad < 5; c++) begin
      e = model(i, kc[i]);
      checks++;
      if (obs[i] !== e) begin
        failures++; bad++;
        $display("FAIL scan[%0d] k=%0d got=%h exp=%h", i, kc[i], obs[i], e);
      end
      if (c == rc) rst[i] = 1'b1;
      if (c == rc + rl) rst[i] = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_line_period(input int i);
    longint fall[$];
    longint rise[$];
    logic   prev;
    do_reset(i, 2);
    prev = obs[i].hs;
    for (int c = 0; c < DT[i] * 800 * 2 + DT[i] * 700 && fall.size() < 3; c++) begin
      @(negedge clk);
      if (prev === 1'b1 && obs[i].hs === 1'b0) fall.push_back(kc[i]);
      if (prev === 1'b0 && obs[i].hs === 1'b1) rise.push_back(kc[i]);
      prev = obs[i].hs;
    end
    checks++;
    if (fall.size() < 3 || rise.size() < 1) begin
      failures++; $display("FAIL hsync_edges[%0d] got=%0d falls exp=3", i, fall.size());
    end else begin
      checks += 3;
      if (fall[0] != longint'(657 * DT[i])) begin
        failures++; $display("FAIL hsync_first_fall[%0d] got=%0d exp=%0d", i, fall[0], 657 * DT[i]);
      end
      if (fall[1] - fall[0] != longint'(800 * DT[i]) || fall[2] - fall[1] != longint'(800 * DT[i])) begin
        failures++; $display("FAIL line_period[%0d] got=%0d exp=%0d", i, fall[1] - fall[0], 800 * DT[i]);
      end
      if (rise[0] - fall[0] != longint'(96 * DT[i])) begin
        failures++; $display("FAIL hsync_width[%0d] got=%0d exp=%0d", i, rise[0] - fall[0], 96 * DT[i]);
      end
    end
  endtask

  task automatic test_frame(input int i);
    longint fall[$];
    longint rise[$];
    longint vbk[$];
    logic   prev;
    int     ht = HV[i] + HF[i] + HS[i] + HB[i];
    int     vt = VV[i] + VF[i] + VS[i] + VB[i];
    int     hi_cnt = 0;
    do_reset(i, 1);
    prev = obs[i].vs;
    for (int c = 0; c < DT[i] * ht * vt * 3 + 20 && fall.size() < 3; c++) begin
      @(negedge clk);
      if (prev === 1'b1 && obs[i].vs === 1'b0) fall.push_back(kc[i]);
      if (prev === 1'b0 && obs[i].vs === 1'b1) rise.push_back(kc[i]);
      if (obs[i].vblank === 1'b1) vbk.push_back(kc[i]);
      prev = obs[i].vs;
    end
    checks++;
    if (fall.size() < 3 || rise.size() < 1 || vbk.size() < 1) begin
      failures++; $display("FAIL frame_edges[%0d] got=%0d falls exp=3", i, fall.size());
    end else begin
      checks += 4;
      if (fall[1] - fall[0] != longint'(DT[i] * ht * vt)) begin
        failures++; $display("FAIL frame_period[%0d] got=%0d exp=%0d", i, fall[1] - fall[0], DT[i] * ht * vt);
      end
      if (rise[0] - fall[0] != longint'(DT[i] * ht * VS[i])) begin
        failures++; $display("FAIL vsync_width[%0d] got=%0d exp=%0d", i, rise[0] - fall[0], DT[i] * ht * VS[i]);
      end
      if (vbk[0] != longint'(DT[i] * ht * VV[i])) begin
        failures++; $display("FAIL vblank_first[%0d] got=%0d exp=%0d", i, vbk[0], DT[i] * ht * VV[i]);
      end
      foreach (vbk[j]) if (vbk[j] >= fall[0] && vbk[j] < fall[1]) hi_cnt++;
      if (hi_cnt != 1) begin
        failures++; $display("FAIL vblank_per_frame[%0d] got=%0d exp=1", i, hi_cnt);
      end
    end
  endtask

  task automatic test_blanking(input int i, input int win, input int exp_white);
    int white = 0;
    int other = 0;
    pat[i] = 1'b0;
    cst[i] = 12'hFFF;
    do_reset(i, 1);
    repeat (win) @(negedge clk);
    for (int c = 0; c < win; c++) begin
      if (obs[i].rgb === 12'hFFF) white++;
      else if (obs[i].rgb !== 12'h000) other++;
      @(negedge clk);
    end
    checks += 2;
    if (white != exp_white) begin
      failures++; $display("FAIL blank_white_clks[%0d] got=%0d exp=%0d", i, white, exp_white);
    end
    if (other != 0) begin
      failures++; $display("FAIL blank_other_clks[%0d] got=%0d exp=0", i, other);
    end
  endtask

  task automatic test_alignment(input int i, input int ylast);
    logic [9:0]  cx;
    logic [8:0]  cy;
    logic [11:0] want;
    bit          found;
    pat[i] = 1'b1;
    key[i] = 12'h000;
    do_reset(i, 1);
    for (int n = 0; n < 4; n++) begin
      cx = (n % 2 == 1) ? 10'(HV[i] - 1) : 10'd0;
      cy = (n >= 2) ? 9'(ylast) : 9'd0;
      want = {cx[3:0], cy[3:0], 4'h5};
      found = 1'b0;
      for (int c = 0; c < DT[i] * 1700 && !found; c++) begin
        if (obs[i].valid === 1'b1 && obs[i].x === cx && obs[i].y === cy) found = 1'b1;
        else @(negedge clk);
      end
      checks++;
      if (!found) begin
        failures++; $display("FAIL align_timeout[%0d] got=none exp=(%0d,%0d)", i, cx, cy);
      end else begin
        repeat (DT[i]) @(negedge clk);
        checks++;
        if (obs[i].rgb !== want) begin
          failures++; $display("FAIL align_rgb[%0d] (%0d,%0d) got=%h exp=%h", i, cx, cy, obs[i].rgb, want);
        end
      end
    end
  endtask

  task automatic test_wrap_reset(input int i);
    int   fr = (HV[i] + HF[i] + HS[i] + HB[i]) * (VV[i] + VF[i] + VS[i] + VB[i]);
    obs_t idle = {10'd0, 9'd0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000};
    pat[i] = 1'b1;
    key[i] = 12'($urandom);
    do_reset(i, 1);
    repeat (fr + fr - 1) @(negedge clk);
    checks++;
    if (obs[i] !== model(i, kc[i])) begin
      failures++; $display("FAIL last_pos[%0d] got=%h exp=%h", i, obs[i], model(i, kc[i]));
    end
    @(negedge clk);
    checks++;
    if (obs[i] !== idle) begin
      failures++; $display("FAIL double_wrap[%0d] got=%h exp=%h", i, obs[i], idle);
    end
    repeat (fr - 1) @(negedge clk);
    rst[i] = 1'b1;
    @(negedge clk);
    rst[i] = 1'b0;
    checks++;
    if (obs[i] !== idle) begin
      failures++; $display("FAIL wrap_reset[%0d] got=%h exp=%h", i, obs[i], idle);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      pat[i] = 1'b0;
      key[i] = 12'h000;
      cst[i] = 12'h000;
    end
    test_reset(0);
    test_reset(1);
    test_model_scan(0, 7000);
    test_model_scan(1, 2000);
    test_model_scan(2, 700);
    test_line_period(0);
    test_line_period(1);
    test_frame(2);
    test_blanking(0, 3200, 2560);
    test_blanking(2, 150, 48);
    test_alignment(0, 1);
    test_alignment(2, VV[2] - 1);
    test_wrap_reset(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Generates 640x480@60 Hz VGA timing from the system clock.
- Drives pix_x, pix_y and pix_valid into the pixel-colour stage, which produces the 12-bit rgb for the current pixel combinationally.
- Registers that rgb back together with hsync and vsync, so everything reaches the pins aligned.
- Emits a one-cycle vblank_start strobe so game logic updates player and obstacle state between frames.

Parameters:
- CLK_DIV, 4: system clocks per pixel; 100 MHz / 4 = 25 MHz. Legal range is 1 and up; 1 means a tick every cycle.
- H_VISIBLE / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48: horizontal timing, in pixels.
- V_VISIBLE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33: vertical timing, in lines.
- SYNC_ACTIVE, 1'b0: polarity of the asserted sync pulse (active-low for this mode).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rgb_in  in  12  colour for the current pix_x/pix_y: R[11:8], G[7:4], B[3:0]
- pix_x  out  10  current visible column 0..639; 0 while blanking
- pix_y  out  9  current visible row 0..479; 0 while blanking
- pix_valid  out  1  high while the counters are in the visible area
- vblank_start  out  1  one-clk strobe when line 480 begins
- hsync  out  1  horizontal sync to the connector
- vsync  out  1  vertical sync to the connector
- vga_r, vga_g, vga_b  out  4 each  registered pixel colour

Behaviour:
- Tick divider:
  - div_cnt runs 0..CLK_DIV-1, wraps to 0.
  - pix_tick is high for one clk when div_cnt == CLK_DIV-1.
  - With CLK_DIV=1, pix_tick is constantly high.
- Counters (10 bit each), advance only on pix_tick:
  - h_cnt runs 0..799 (H_TOTAL = 800), then wraps to 0.
  - On an h_cnt wrap, v_cnt increments over 0..524 (V_TOTAL = 525) and wraps to 0.
  - No other counter states exist; an out-of-range value is unreachable.
- Stage 1 decode, combinational from the counter registers:
  - vis = (h_cnt < 640) && (v_cnt < 480).
  - pix_valid = vis.
  - pix_x = vis ? h_cnt : 0.
  - pix_y = vis ? v_cnt[8:0] : 0.
  - hs_raw is asserted for 656 <= h_cnt <= 751.
  - vs_raw is asserted for 490 <= v_cnt <= 491.
- Stage 2 output register, updated only on pix_tick:
  - {vga_r, vga_g, vga_b} <= vis ? rgb_in : 12'h000.
  - hsync <= hs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE; vsync is built the same way from vs_raw.
  - Latency from counter state to pins is exactly one pixel tick, and colour and sync stay mutually aligned.
  - Between ticks the outputs hold.
- vblank_start:
  - High for exactly one clk, on the clk where pix_tick is high and the counters transition into h_cnt = 0, v_cnt = 480.
  - Low at all other times.
- Reset (rst high at a rising clk edge):
  - div_cnt, h_cnt and v_cnt go to 0.
  - vga_r/g/b go to 0, vblank_start goes to 0.
  - hsync and vsync go to ~SYNC_ACTIVE (inactive).
  - Reset is synchronous and overrides pix_tick in the same cycle.
  - Reset mid-frame abandons the frame; the first tick after release shows pixel (0,0) on stage 1.
- The rgb_in width is 12 bits with no conversion. rgb_in is ignored outside the visible area; the blanking colour is always forced to 0 because monitors need black in the porches.
- Simultaneous horizontal and vertical wrap (h_cnt=799, v_cnt=524) on one tick gives 0/0 on the next clk; no extra cycle is spent.

Decomposition:
- Package vga_timing_pkg holds:
  - the H_*/V_* constants;
  - derived constants H_TOTAL=800, V_TOTAL=525, H_SYNC_START=656, H_SYNC_END=751, V_SYNC_START=490, V_SYNC_END=491;
  - the RGB_BLACK=12'h000 constant.
- Sub-module vga_pix_tick (parameter CLK_DIV; ports clk, rst, pix_tick) contains the divider.
- Counters, decode and the output register stay in vga_timing_ctrl.

Test Plan:
1. Reset values: hold rst for 3 clks mid-frame → vga_rgb=0, hsync=vsync=1, vblank_start=0, pix_x=pix_y=0, pix_valid=1. After release, the first tick shows pix_x=1.
2. Tick and line period (CLK_DIV=4): count clks between successive hsync falling edges → exactly 3200. hsync low for 384 clks. The falling edge occurs 4 clks after h_cnt reaches 656.
3. Frame period: count vsync falling edges → 1,680,000 clks apart. vsync low for 6400 clks. Exactly one vblank_start pulse per frame, coincident with v_cnt becoming 480.
4. Blanking gating: drive rgb_in=12'hFFF constantly → vga_rgb=FFF only on the tick after each visible pixel. It is 000 during h_cnt 640..799 (delayed one tick) and during all of v_cnt 480..524.
5. Alignment: model the colour stage as rgb_in = {pix_x[3:0], pix_y[3:0], 4'h5} → pins show the value of the previous tick's coordinates at every visible pixel. Check at (0,0), (639,0), (0,479) and (639,479).
6. CLK_DIV=1: pix_tick is always high, the line is 800 clks and all of the above hold scaled; reset asserted at h_cnt=799, v_cnt=524 still yields zeros next clk.
